// File: rtl/hack_pkg.sv
// Hack PC sequencer shared definitions.
// Jump encodings, FSM state type and address width default.
package hack_pkg;

    localparam int HACK_ADDR_W = 15;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Hack C-instruction branch condition.
// jump bits are {lt, eq, gt}; zr/ng come straight from the ALU.
module hack_jump_cond (
    input  logic       is_c,
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    logic lt;
    logic eq;
    logic gt;

    assign lt = jump[2] & ng;
    assign eq = jump[1] & zr;
    assign gt = jump[0] & ~ng & ~zr;

    // zr and ng both high is not filtered out
    assign take = is_c & (lt | eq | gt);

endmodule

// File: rtl/hack_pc_seq.sv
// Hack program-counter sequencer with self-loop halt detect.
// Optional retired counter: define HACK_PC_RETIRE_CNT_EN.
module hack_pc_seq
    import hack_pkg::*;
#(
    parameter int ADDR_W   = HACK_ADDR_W,
    parameter int HALT_CNT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              is_c,
    input  logic [2:0]        jump,
    input  logic              alu_zr,
    input  logic              alu_ng,
    input  logic [15:0]       a_reg,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_out,
    output logic              jump_taken,
    output logic              halted
`ifdef HACK_PC_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam int CW =
        (HALT_CNT > 0) ? $clog2(HALT_CNT + 1) : 1;
    localparam logic [CW-1:0] HALT_W = CW'(HALT_CNT);

    state_t            state;
    logic [CW-1:0]     loop_cnt;
    logic [CW-1:0]     loop_inc;
    logic [ADDR_W-1:0] target;
    logic              take;
    logic              self_jmp;
    logic              halt_hit;

    assign target = a_reg[ADDR_W-1:0];

    if (ADDR_W < 16) begin : g_hi
        logic unused_a_hi;
        assign unused_a_hi = ^a_reg[15:ADDR_W];
    end

    hack_jump_cond u_cond (
        .is_c (is_c),
        .jump (jump),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (take)
    );

    assign self_jmp = take && (target == pc_out);

    assign loop_inc = (loop_cnt == HALT_W)
                    ? loop_cnt
                    : loop_cnt + 1'b1;

    assign halt_hit = (HALT_CNT != 0)
                   && self_jmp
                   && (loop_inc == HALT_W);

    // PC advance, loop counter and RUN/HALT state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out     <= '0;
            jump_taken <= 1'b0;
            halted     <= 1'b0;
            state      <= RUN;
            loop_cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (en) begin
                        unique case (1'b1)
                            take: begin
                                pc_out     <= target;
                                jump_taken <= 1'b1;
                            end
                            default: begin
                                pc_out     <= pc_out + 1'b1;
                                jump_taken <= 1'b0;
                            end
                        endcase
                        loop_cnt <= self_jmp ? loop_inc : '0;
                        if (halt_hit) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    jump_taken <= 1'b0;
                    if (resume) begin
                        state    <= RUN;
                        halted   <= 1'b0;
                        loop_cnt <= '0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef HACK_PC_RETIRE_CNT_EN
    // count every advance made in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (state == RUN && en) begin
            retired <= retired + 1'b1;
        end
    end
`endif

endmodule
